vec_pair_loader: RTL

VEC_PAIR_LOADER -- requirements
Module: vec_pair_loader

---
 rtl/vec_pair_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vec_pair_loader.sv
// Streams (a,b) operand pairs into two vector RAMs, then hands the RAMs to a
// dotprod core through ap_memory-style ports and sequences its start/done handshake.
module vec_pair_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_a,
    input  logic [31:0] s_b,
    input  logic        s_last,
    input  logic [31:0] a_address0,
    input  logic        a_ce0,
    input  logic        a_we0,
    input  logic [31:0] a_ad0,
    output logic [31:0] a_q0,
    input  logic [31:0] b_address0,
    input  logic        b_ce0,
    input  logic        b_we0,
    input  logic [31:0] b_ad0,
    output logic [31:0] b_q0,
    output logic [31:0] n,
    output logic        ap_start,
    input  logic        ap_done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [31:0]     n_r;
    logic            ap_start_r;
    logic            overflow_r;
    logic            s_ready_r;
    logic [31:0]     a_q_r;
    logic [31:0]     b_q_r;
    logic [31:0]     ram_a_r [DEPTH];
    logic [31:0]     ram_b_r [DEPTH];

    logic            accept_s;
    logic            last_beat_s;
    logic            a_in_range_s;
    logic            b_in_range_s;
    logic            a_wr_s;
    logic            b_wr_s;
    logic            stream_wr_a_s;
    logic            stream_wr_b_s;

    // Beat acceptance, address range checks and write-port arbitration.
    always_comb begin
        accept_s      = 1'b0;
        last_beat_s   = 1'b0;
        a_in_range_s  = 1'b0;
        b_in_range_s  = 1'b0;
        a_wr_s        = 1'b0;
        b_wr_s        = 1'b0;
        stream_wr_a_s = 1'b0;
        stream_wr_b_s = 1'b0;
        accept_s      = s_valid & s_ready_r & (state_r == ST_LOAD);
        last_beat_s   = s_last | (wr_ptr_r == AW'(DEPTH - 1));
        a_in_range_s  = (a_address0 < 32'(DEPTH));
        b_in_range_s  = (b_address0 < 32'(DEPTH));
        a_wr_s        = a_ce0 & a_we0 & a_in_range_s;
        b_wr_s        = b_ce0 & b_we0 & b_in_range_s;
        // A dotprod write to the slot being streamed wins, so the stream write is dropped.
        stream_wr_a_s = accept_s & ~(a_wr_s & (a_address0[AW-1:0] == wr_ptr_r));
        stream_wr_b_s = accept_s & ~(b_wr_s & (b_address0[AW-1:0] == wr_ptr_r));
    end

    // Load/run/drain sequencer with registered handshake outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r    <= ST_LOAD;
            wr_ptr_r   <= {AW{1'b0}};
            n_r        <= 32'd0;
            ap_start_r <= 1'b0;
            overflow_r <= 1'b0;
            s_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    s_ready_r  <= 1'b1;
                    ap_start_r <= 1'b0;
                    if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                        if (last_beat_s) begin
                            state_r    <= ST_RUN;
                            n_r        <= 32'(wr_ptr_r) + 32'd1;
                            s_ready_r  <= 1'b0;
                            ap_start_r <= 1'b1;
                            // Full RAM without s_last means the vector was truncated.
                            if (!s_last) begin
                                overflow_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    s_ready_r  <= 1'b0;
                    ap_start_r <= 1'b1;
                    if (ap_done) begin
                        state_r    <= ST_DRAIN;
                        ap_start_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    s_ready_r  <= 1'b0;
                    ap_start_r <= 1'b0;
                    if (!ap_done) begin
                        state_r   <= ST_LOAD;
                        wr_ptr_r  <= {AW{1'b0}};
                        s_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_LOAD;
                    s_ready_r  <= 1'b0;
                    ap_start_r <= 1'b0;
                end
            endcase
        end
    end

    // Vector RAM storage; contents deliberately survive reset.
    always_ff @(posedge ap_clk) begin
        if (a_wr_s) begin
            ram_a_r[a_address0[AW-1:0]] <= a_ad0;
        end
        if (stream_wr_a_s) begin
            ram_a_r[wr_ptr_r] <= s_a;
        end
        if (b_wr_s) begin
            ram_b_r[b_address0[AW-1:0]] <= b_ad0;
        end
        if (stream_wr_b_s) begin
            ram_b_r[wr_ptr_r] <= s_b;
        end
    end

    // Write-first read data registers; out-of-range reads return zero, out-of-range writes hold.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q_r <= 32'd0;
            b_q_r <= 32'd0;
        end else begin
            if (a_ce0) begin
                if (a_we0) begin
                    if (a_in_range_s) begin
                        a_q_r <= a_ad0;
                    end
                end else if (a_in_range_s) begin
                    a_q_r <= ram_a_r[a_address0[AW-1:0]];
                end else begin
                    a_q_r <= 32'd0;
                end
            end
            if (b_ce0) begin
                if (b_we0) begin
                    if (b_in_range_s) begin
                        b_q_r <= b_ad0;
                    end
                end else if (b_in_range_s) begin
                    b_q_r <= ram_b_r[b_address0[AW-1:0]];
                end else begin
                    b_q_r <= 32'd0;
                end
            end
        end
    end

    assign s_ready  = s_ready_r;
    assign n        = n_r;
    assign ap_start = ap_start_r;
    assign overflow = overflow_r;
    assign a_q0     = a_q_r;
    assign b_q0     = b_q_r;

endmodule
